// File: rtl/shift_pkg.sv
// Shared constants for the shift_seq8 sequencer: widths, op codes, FSM state encoding.
package shift_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned OP_W  = 3;

    localparam logic [OP_W-1:0] OP_NOP = 3'b000;
    localparam logic [OP_W-1:0] OP_LSL = 3'b001;
    localparam logic [OP_W-1:0] OP_LSR = 3'b010;
    localparam logic [OP_W-1:0] OP_ASR = 3'b011;
    localparam logic [OP_W-1:0] OP_ROL = 3'b100;
    localparam logic [OP_W-1:0] OP_ROR = 3'b101;
    localparam logic [OP_W-1:0] OP_SSL = 3'b110;
    localparam logic [OP_W-1:0] OP_SSR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_seq8_if.sv
// Command / register-loop bus between the controller, shift_seq8 and the 8-bit register.
// Optional abort input is present when SHIFT_SEQ8_ABORT_EN is defined.
interface shift_seq8_if;
    import shift_pkg::*;

    logic                start;
    logic [OP_W-1:0]     op;
    logic [CNT_W-1:0]    amount;
    logic [WIDTH-1:0]    load_val;
    logic                shin;
    logic [WIDTH-1:0]    q;
    logic [WIDTH-1:0]    d;
    logic                busy;
    logic                done;
`ifdef SHIFT_SEQ8_ABORT_EN
    logic                abort;

    modport master (output start, op, amount, load_val, shin, q, abort,
                    input  d, busy, done);
    modport slave  (input  start, op, amount, load_val, shin, q, abort,
                    output d, busy, done);
`else
    modport master (output start, op, amount, load_val, shin, q,
                    input  d, busy, done);
    modport slave  (input  start, op, amount, load_val, shin, q,
                    output d, busy, done);
`endif

endinterface

// File: rtl/shift8_unit.sv
// Combinational one-bit shift/rotate of the register value selected by op.
module shift8_unit
    import shift_pkg::*;
(
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] q,
    input  logic             shin,
    output logic [WIDTH-1:0] res_c
);

    always_comb begin
        res_c = q;
        case (op)
            OP_NOP:  res_c = q;
            OP_LSL:  res_c = {q[WIDTH-2:0], 1'b0};
            OP_LSR:  res_c = {1'b0, q[WIDTH-1:1]};
            OP_ASR:  res_c = {q[WIDTH-1], q[WIDTH-1:1]};
            OP_ROL:  res_c = {q[WIDTH-2:0], q[WIDTH-1]};
            OP_ROR:  res_c = {q[0], q[WIDTH-1:1]};
            OP_SSL:  res_c = {q[WIDTH-2:0], shin};
            OP_SSR:  res_c = {shin, q[WIDTH-1:1]};
            default: res_c = q;
        endcase
    end

endmodule

// File: rtl/shift_seq8.sv
// Next-state sequencer for the 8-bit shift register: loads, then applies one shift per edge.
// Define SHIFT_SEQ8_ABORT_EN to add the abort input that ends a command early.
module shift_seq8
    import shift_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    shift_seq8_if.slave bus
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   shift_c;
    logic [WIDTH-1:0]   d_c;
    logic               abort_c;

`ifdef SHIFT_SEQ8_ABORT_EN
    assign abort_c = bus.abort;
`else
    assign abort_c = 1'b0;
`endif

    shift8_unit u_unit (
        .op    (op_q),
        .q     (bus.q),
        .shin  (bus.shin),
        .res_c (shift_c)
    );

    // Next state, counter and the d-mux (hold / load / shifted value)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        d_c     = bus.q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    d_c     = bus.load_val;
                    op_d    = bus.op;
                    cnt_d   = bus.amount;
                    state_d = (bus.amount != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (abort_c) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    d_c   = shift_c;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NOP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.d    = d_c;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_shift_seq8.sv
// Closed-loop bench: shift_seq8 drives an 8-bit register whose q feeds back into it.
module tb_shift_seq8;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic abort_drv = 1'b0;
    logic [7:0] q_reg;
    int vectors = 0;
    int miscompares = 0;

    shift_seq8_if bus ();

    shift_seq8 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

`ifdef SHIFT_SEQ8_ABORT_EN
    assign bus.abort = abort_drv;
`endif

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q_reg <= 8'h00;
        else          q_reg <= bus.d;
    end
    assign bus.q = q_reg;

    // Reference: apply the op `amt` times using plain integer arithmetic
    function automatic logic [7:0] ref_model(input int op, input int v, input int amt,
                                             input logic [6:0] sh);
        int x = v;
        for (int i = 0; i < amt; i++) begin
            int s = int'(sh[i]);
            case (op)
                1: x = (x * 2) % 256;
                2: x = x / 2;
                3: x = x / 2 + ((x >= 128) ? 128 : 0);
                4: x = (x * 2) % 256 + x / 128;
                5: x = x / 2 + (x % 2) * 128;
                6: x = (x * 2) % 256 + s;
                7: x = x / 2 + s * 128;
                default: x = x;
            endcase
        end
        return 8'(x);
    endfunction

    // Issue one command and observe 12 cycles after the acceptance edge
    task automatic run_cmd(input logic [2:0] op_i, input logic [2:0] amt, input logic [7:0] ld,
                           input logic [6:0] sh, input int extra_start_at, input int abort_at,
                           output int done_at, output int done_cnt, output int busy_cnt,
                           output logic [7:0] q_done);
        done_at = -1; done_cnt = 0; busy_cnt = 0; q_done = 8'hxx;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op_i; bus.amount = amt; bus.load_val = ld;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int n = 0; n < 12; n++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = n;
                    q_done  = bus.q;
                end
            end
            bus.shin = (n < 7) ? sh[n] : 1'b0;
            if (n == extra_start_at) begin
                bus.start = 1'b1; bus.load_val = 8'hFF; bus.op = OP_ROR; bus.amount = 3'd7;
            end else begin
                bus.start = 1'b0;
            end
            abort_drv = (n == abort_at);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        abort_drv = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy);
        end
        vectors++;
        if (bus.done !== 1'b0) begin
            miscompares++; $display("FAIL reset_done got %b want 0", bus.done);
        end
        vectors++;
        if (bus.d !== 8'h00 || bus.q !== 8'h00) begin
            miscompares++; $display("FAIL reset_dq got d=%h q=%h want 00/00", bus.d, bus.q);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.q !== 8'h00) begin
            miscompares++; $display("FAIL idle_hold got busy=%b q=%h want 0/00", bus.busy, bus.q);
        end
    endtask

    task automatic test_lsl_latency();
        int da, dc, bc; logic [7:0] qd;
        run_cmd(OP_LSL, 3'd3, 8'h81, 7'd0, -1, -1, da, dc, bc, qd);
        vectors++;
        if (qd !== 8'h08) begin miscompares++; $display("FAIL lsl_result got %h want 08", qd); end
        vectors++;
        if (da !== 3) begin miscompares++; $display("FAIL lsl_done_at got %0d want 3", da); end
        vectors++;
        if (dc !== 1) begin miscompares++; $display("FAIL lsl_done_width got %0d want 1", dc); end
        vectors++;
        if (bc !== 4) begin miscompares++; $display("FAIL lsl_busy got %0d want 4", bc); end
    endtask

    task automatic test_ops();
        logic [2:0] ops [3] = '{OP_ASR, OP_ROL, OP_ROR};
        logic [2:0] amts[3] = '{3'd2, 3'd4, 3'd1};
        logic [7:0] lds [3] = '{8'h80, 8'hA5, 8'h01};
        logic [7:0] exps[3] = '{8'hE0, 8'h5A, 8'h80};
        int da, dc, bc; logic [7:0] qd;
        for (int i = 0; i < 3; i++) begin
            run_cmd(ops[i], amts[i], lds[i], 7'd0, -1, -1, da, dc, bc, qd);
            vectors++;
            if (qd !== exps[i] || da !== int'(amts[i]) || dc !== 1) begin
                miscompares++;
                $display("FAIL op%0d got q=%h done_at=%0d pulses=%0d want q=%h done_at=%0d pulses=1",
                         ops[i], qd, da, dc, exps[i], amts[i]);
            end
        end
    endtask

    task automatic test_serial();
        int da, dc, bc; logic [7:0] qd;
        run_cmd(OP_SSL, 3'd7, 8'h00, 7'b1001101, -1, -1, da, dc, bc, qd);
        vectors++;
        if (qd !== 8'h59 || da !== 7) begin
            miscompares++; $display("FAIL ssl_serial got q=%h done_at=%0d want 59/7", qd, da);
        end
    endtask

    task automatic test_zero_amount();
        int da, dc, bc; logic [7:0] qd;
        run_cmd(OP_LSR, 3'd0, 8'h3C, 7'd0, -1, -1, da, dc, bc, qd);
        vectors++;
        if (qd !== 8'h3C) begin miscompares++; $display("FAIL zero_result got %h want 3C", qd); end
        vectors++;
        if (da !== 0 || bc !== 1) begin
            miscompares++; $display("FAIL zero_timing got done_at=%0d busy=%0d want 0/1", da, bc);
        end
    endtask

    task automatic test_busy_start();
        int da, dc, bc; logic [7:0] qd;
        run_cmd(OP_LSL, 3'd5, 8'h01, 7'd0, 1, -1, da, dc, bc, qd);
        vectors++;
        if (qd !== 8'h20 || dc !== 1 || bc !== 6) begin
            miscompares++;
            $display("FAIL busy_start got q=%h pulses=%0d busy=%0d want 20/1/6", qd, dc, bc);
        end
    endtask

    task automatic test_reset_mid();
        int da, dc, bc; logic [7:0] qd;
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_LSL; bus.amount = 3'd5; bus.load_val = 8'h01;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.q !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid got busy=%b done=%b q=%h want 0/0/00", bus.busy, bus.done, bus.q);
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_cmd(OP_ROR, 3'd1, 8'h01, 7'd0, -1, -1, da, dc, bc, qd);
        vectors++;
        if (qd !== 8'h80 || da !== 1) begin
            miscompares++; $display("FAIL after_reset got q=%h done_at=%0d want 80/1", qd, da);
        end
    endtask

`ifdef SHIFT_SEQ8_ABORT_EN
    task automatic test_abort();
        int da, dc, bc; logic [7:0] qd;
        run_cmd(OP_LSL, 3'd6, 8'h01, 7'd0, -1, 2, da, dc, bc, qd);
        vectors++;
        if (qd !== 8'h04 || da !== 3 || dc !== 1) begin
            miscompares++;
            $display("FAIL abort got q=%h done_at=%0d pulses=%0d want 04/3/1", qd, da, dc);
        end
    endtask
`endif

    task automatic test_random();
        int da, dc, bc; logic [7:0] qd, exp_q;
        logic [2:0] op_r, amt_r; logic [7:0] ld_r; logic [6:0] sh_r;
        for (int i = 0; i < 24; i++) begin
            op_r  = 3'($urandom_range(0, 7));
            amt_r = 3'($urandom_range(0, 7));
            ld_r  = 8'($urandom);
            sh_r  = 7'($urandom);
            exp_q = ref_model(int'(op_r), int'(ld_r), int'(amt_r), sh_r);
            run_cmd(op_r, amt_r, ld_r, sh_r, -1, -1, da, dc, bc, qd);
            vectors++;
            if (qd !== exp_q || da !== int'(amt_r) || dc !== 1 || bc !== int'(amt_r) + 1) begin
                miscompares++;
                $display("FAIL rand%0d op=%0d amt=%0d ld=%h got q=%h done_at=%0d pulses=%0d busy=%0d want q=%h",
                         i, op_r, amt_r, ld_r, qd, da, dc, bc, exp_q);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.op = OP_NOP; bus.amount = '0; bus.load_val = '0; bus.shin = 1'b0;
        #12;
        test_reset();
        test_lsl_latency();
        test_ops();
        test_serial();
        test_zero_amount();
        test_busy_start();
        test_reset_mid();
`ifdef SHIFT_SEQ8_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
